phys_free_list: RTL and testbench
=================================

PHYS_FREE_LIST -- requirements
Module: phys_free_list

Interface
REQ-001 The block SHALL have parameter NUM_PREGS, default 64, giving the physical register count (6-bit tags).
REQ-002 The block SHALL have parameter NUM_AREGS, default 32, giving the architectural register count, which is also the reset identity mapping p0..p31.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  is the reset: asynchronous, active-high.
REQ-005 Port alloc_req_a  input  1  requests one free tag for rename slot A.
REQ-006 Port alloc_req_b  input  1  requests one free tag for rename slot B.
REQ-007 Port alloc_grant  output  1  means all requested tags are granted this cycle.
REQ-008 Port alloc_reg_a  output  6  is the tag for slot A.
REQ-009 Port alloc_reg_b  output  6  is the tag for slot B.
REQ-010 Port free_valid1  input  1  means the retiring ROB entry 1 returns free_reg1 to the pool.
REQ-011 Port free_reg1  input  6  is the returned tag (rd_old of entry 1).
REQ-012 Port free_valid2  input  1  means the retiring ROB entry 2 returns free_reg2 to the pool.
REQ-013 Port free_reg2  input  6  is the returned tag (rd_old of entry 2).
REQ-014 Port free_count  output  7  is the number of tags currently in the pool.
REQ-015 Port empty  output  1  is high when free_count==0.
REQ-016 Port overflow_err  output  1  is a sticky error flag.

Function
REQ-017 Storage SHALL be a circular FIFO of NUM_PREGS 6-bit entries with 6-bit head and tail pointers that wrap modulo NUM_PREGS, plus a 7-bit count.
REQ-018 n_req = alloc_req_a + alloc_req_b; alloc_grant SHALL be combinational: 1 when count >= n_req (including n_req==0), else 0.
REQ-019 If both requests are high: alloc_reg_a=fifo[head] and alloc_reg_b=fifo[head+1]. If only B is high: alloc_reg_b=fifo[head]. Unrequested outputs are don't-care.
REQ-020 Allocation SHALL be all-or-nothing: on a granted edge head advances by n_req; when not granted, head is unchanged and no partial grant occurs.
REQ-021 Frees SHALL push at tail in order free_reg1, then free_reg2; tail advances by the number pushed.
REQ-022 A free with free_reg==0 SHALL be ignored, since p0 is permanently mapped to x0.
REQ-023 There SHALL be no bypass: tags freed in cycle N become allocatable no earlier than cycle N+1, and alloc_grant in cycle N depends only on the registered count.
REQ-024 count_next SHALL equal count - (granted ? n_req : 0) + pushed, with allocation and free on the same edge both applied.
REQ-025 If count - granted_allocs + pushes would exceed NUM_PREGS, all pushes that edge SHALL be dropped and overflow_err set; allocation still proceeds.
REQ-026 overflow_err SHALL stay set until reset.
REQ-027 free_count and empty SHALL be registered-state views with zero latency from count.
REQ-028 No duplicate-tag checking is performed beyond REQ-025.

Reset
REQ-029 While reset is high: fifo[i]=NUM_AREGS+i for i in 0..NUM_PREGS-NUM_AREGS-1, head=0, tail=NUM_PREGS-NUM_AREGS, count=NUM_PREGS-NUM_AREGS (32), overflow_err=0.
REQ-030 Reset asserted mid-operation SHALL immediately restore the REQ-029 state, discarding any in-flight allocation or free.
REQ-031 The first edge after reset deasserts SHALL behave normally.

Verification
REQ-032 Reset, then alloc_req_a=alloc_req_b=1 for one cycle -> alloc_grant=1, alloc_reg_a=32, alloc_reg_b=33; next cycle free_count=30.
REQ-033 Request 2 tags per cycle for 16 cycles -> last grant gives 62/63, then empty=1; next dual request -> alloc_grant=0 and head holds; a single request with count=1 (built by one free of tag 40) -> grant, alloc_reg_a=40.
REQ-034 At empty, free_valid1=1 with free_reg1=45 plus alloc_req_a=1 in the same cycle -> alloc_grant=0 that cycle; next cycle alloc_reg_a=45 with grant=1.
REQ-035 Cycle 100 allocations/frees so tail and head wrap past 63 -> tags return in FIFO order with free_count always equal to the reference-model count.
REQ-036 free_valid1=1 with free_reg1=0 -> free_count unchanged; with count=63, two frees of tags 5 and 6 -> overflow_err=1, count stays 63, and the flag persists until reset.

Source files
------------

// File: rtl/phys_free_list.sv
// Physical register free list for a two-wide rename stage.
// Circular FIFO of free physical tags with all-or-nothing dual allocation
// at the head and up to two retirement frees pushed at the tail.
// Newly freed tags are never bypassed to the allocation outputs.
module phys_free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  localparam int TW = $clog2(NUM_PREGS),
  localparam int CW = $clog2(NUM_PREGS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alloc_req_a,
  input  logic          alloc_req_b,
  output logic          alloc_grant,
  output logic [TW-1:0] alloc_reg_a,
  output logic [TW-1:0] alloc_reg_b,
  input  logic          free_valid1,
  input  logic [TW-1:0] free_reg1,
  input  logic          free_valid2,
  input  logic [TW-1:0] free_reg2,
  output logic [CW-1:0] free_count,
  output logic          empty,
  output logic          overflow_err
);

  localparam int RESET_FREE = NUM_PREGS - NUM_AREGS;

  logic [TW-1:0] fifo_reg [NUM_PREGS];
  logic [TW-1:0] head_reg, head_next;
  logic [TW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;
  logic          ovf_reg, ovf_next;

  logic [1:0]    n_req;
  logic [1:0]    n_alloc;
  logic [1:0]    n_push;
  logic [1:0]    n_written;
  logic          push1, push2;
  logic          wr1, wr2;
  logic          overflow_hit;
  logic [CW:0]   count_after;
  logic [TW-1:0] head_plus1;
  logic [TW-1:0] tail_slot2;

  logic [NUM_PREGS-1:0] we1_sel;
  logic [NUM_PREGS-1:0] we2_sel;

  // Pointer advance with wrap modulo NUM_PREGS (works for non-power-of-two sizes too).
  function automatic logic [TW-1:0] ptr_add(input logic [TW-1:0] ptr, input logic [1:0] n);
    int s;
    s = int'(ptr) + int'(n);
    if (s >= NUM_PREGS) s = s - NUM_PREGS;
    return TW'(s);
  endfunction

  // Grant, allocation read-out and free/overflow bookkeeping from registered state only.
  always_comb begin
    n_req        = {1'b0, alloc_req_a} + {1'b0, alloc_req_b};
    alloc_grant  = (count_reg >= CW'(n_req));
    head_plus1   = ptr_add(head_reg, 2'd1);
    alloc_reg_a  = fifo_reg[head_reg];
    // B takes the second tag only when A is also allocating this cycle.
    alloc_reg_b  = alloc_req_a ? fifo_reg[head_plus1] : fifo_reg[head_reg];

    // p0 is hard-wired to x0 and must never re-enter the pool.
    push1        = free_valid1 && (free_reg1 != '0);
    push2        = free_valid2 && (free_reg2 != '0);
    n_push       = {1'b0, push1} + {1'b0, push2};
    n_alloc      = alloc_grant ? n_req : 2'd0;

    count_after  = {1'b0, count_reg} - (CW+1)'(n_alloc) + (CW+1)'(n_push);
    overflow_hit = (count_after > (CW+1)'(NUM_PREGS));

    // On overflow both pushes are dropped; allocation is unaffected.
    wr1          = push1 && !overflow_hit;
    wr2          = push2 && !overflow_hit;
    n_written    = {1'b0, wr1} + {1'b0, wr2};
    tail_slot2   = push1 ? ptr_add(tail_reg, 2'd1) : tail_reg;

    head_next    = ptr_add(head_reg, n_alloc);
    tail_next    = ptr_add(tail_reg, n_written);
    count_next   = overflow_hit ? (count_reg - CW'(n_alloc)) : count_after[CW-1:0];
    ovf_next     = ovf_reg || overflow_hit;
  end

  // Per-entry write decode for the two tail pushes.
  for (genvar gi = 0; gi < NUM_PREGS; gi++) begin : g_wr_dec
    assign we1_sel[gi] = wr1 && (tail_reg == TW'(gi));
    assign we2_sel[gi] = wr2 && (tail_slot2 == TW'(gi));
  end

  // FIFO storage: reset loads the tags not covered by the identity mapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        fifo_reg[i] <= (i < RESET_FREE) ? TW'(NUM_AREGS + i) : '0;
      end
    end else begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        if (we1_sel[i]) fifo_reg[i] <= free_reg1;
        else if (we2_sel[i]) fifo_reg[i] <= free_reg2;
      end
    end
  end

  // Head/tail pointers, occupancy count and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= TW'(RESET_FREE);
      count_reg <= CW'(RESET_FREE);
      ovf_reg   <= 1'b0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign free_count   = count_reg;
  assign empty        = (count_reg == '0);
  assign overflow_err = ovf_reg;

endmodule

// File: tb/tb_phys_free_list.sv
// Randomised + directed scoreboard bench for phys_free_list.
// The reference model is a plain queue of free tags: allocation pops the
// front, frees push the back, and an over-full push set is dropped.
module tb_phys_free_list;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       alloc_req_a = 1'b0;
  logic       alloc_req_b = 1'b0;
  logic       alloc_grant;
  logic [5:0] alloc_reg_a;
  logic [5:0] alloc_reg_b;
  logic       free_valid1 = 1'b0;
  logic [5:0] free_reg1 = '0;
  logic       free_valid2 = 1'b0;
  logic [5:0] free_reg2 = '0;
  logic [6:0] free_count;
  logic       empty;
  logic       overflow_err;

  phys_free_list #(.NUM_PREGS(64), .NUM_AREGS(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_req_a  (alloc_req_a),
    .alloc_req_b  (alloc_req_b),
    .alloc_grant  (alloc_grant),
    .alloc_reg_a  (alloc_reg_a),
    .alloc_reg_b  (alloc_reg_b),
    .free_valid1  (free_valid1),
    .free_reg1    (free_reg1),
    .free_valid2  (free_valid2),
    .free_reg2    (free_reg2),
    .free_count   (free_count),
    .empty        (empty),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit chk_a;
    bit chk_b;
    bit grant;
    bit emp;
    bit ovf;
    int ra;
    int rb;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   pool[$];   // reference free list, front = next tag handed out
  int   held[$];   // tags the bench has been given and may later free
  bit   m_ovf;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   txn      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s txn %0d: got %0d, expected %0d", name, txn, act, expv);
    end
  endtask

  // Monitor: compare the DUT against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      $display("txn %0d: grant=%0b a=%0d b=%0d count=%0d empty=%0b ovf=%0b",
               txn, alloc_grant, alloc_reg_a, alloc_reg_b, free_count, empty, overflow_err);
      check("alloc_grant", 32'(alloc_grant), 32'(e.grant));
      if (e.chk_a) check("alloc_reg_a", 32'(alloc_reg_a), e.ra);
      if (e.chk_b) check("alloc_reg_b", 32'(alloc_reg_b), e.rb);
      check("free_count", 32'(free_count), e.cnt);
      check("empty", 32'(empty), 32'(e.emp));
      check("overflow_err", 32'(overflow_err), 32'(e.ovf));
      txn++;
    end
  end

  task automatic model_reset();
    pool.delete();
    held.delete();
    for (int i = 0; i < 32; i++) pool.push_back(32 + i);
    m_ovf = 1'b0;
  endtask

  // Build the expectation from the pre-edge model, then optionally apply the edge.
  task automatic expect_and_apply(input bit a, input bit b, input bit fv1, input int fr1,
                                  input bit fv2, input int fr2, input bit apply);
    exp_t e;
    int   n;
    int   pushes[$];
    n = int'(a) + int'(b);
    e.grant = (pool.size() >= n);
    e.chk_a = a && e.grant;
    e.chk_b = b && e.grant;
    e.ra    = e.chk_a ? pool[0] : 0;
    e.rb    = e.chk_b ? (a ? pool[1] : pool[0]) : 0;
    e.cnt   = pool.size();
    e.emp   = (pool.size() == 0);
    e.ovf   = m_ovf;
    exp_q.push_back(e);
    if (!apply) return;
    if (e.grant) begin
      for (int k = 0; k < n; k++) held.push_back(pool.pop_front());
    end
    if (fv1 && fr1 != 0) pushes.push_back(fr1);
    if (fv2 && fr2 != 0) pushes.push_back(fr2);
    if (pool.size() + pushes.size() > 64) m_ovf = 1'b1;
    else foreach (pushes[k]) pool.push_back(pushes[k]);
  endtask

  task automatic cycle(input bit a, input bit b, input bit fv1, input int fr1,
                       input bit fv2, input int fr2);
    @(posedge clk);
    #1;
    alloc_req_a = a;
    alloc_req_b = b;
    free_valid1 = fv1;
    free_reg1   = 6'(fr1);
    free_valid2 = fv2;
    free_reg2   = 6'(fr2);
    expect_and_apply(a, b, fv1, fr1, fv2, fr2, 1'b1);
  endtask

  task automatic idle_inputs();
    alloc_req_a = 1'b0;
    alloc_req_b = 1'b0;
    free_valid1 = 1'b0;
    free_reg1   = '0;
    free_valid2 = 1'b0;
    free_reg2   = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle_inputs();
    model_reset();
    expect_and_apply(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Reset raised between clock edges while a dual allocation and a free are pending.
  task automatic mid_op_reset();
    @(posedge clk);
    #1;
    alloc_req_a = 1'b1;
    alloc_req_b = 1'b1;
    free_valid1 = 1'b1;
    free_reg1   = 6'd7;
    #2;
    reset = 1'b1;
    model_reset();
    expect_and_apply(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    @(negedge clk);
    #1;
    idle_inputs();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    do_reset();

    // First dual allocation after reset, then drain the pool completely.
    for (int i = 0; i < 16; i++) cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);          // empty: no grant, head holds
    cycle(0, 0, 1, 40, 0, 0);         // one free of tag 40
    cycle(1, 0, 0, 0, 0, 0);          // single grant of 40
    cycle(1, 0, 1, 45, 0, 0);         // free not visible yet: no grant
    cycle(1, 0, 0, 0, 0, 0);          // now 45 is granted
    cycle(0, 1, 1, 12, 1, 13);
    cycle(0, 1, 0, 0, 0, 0);          // B alone takes the head tag
    cycle(0, 0, 1, 0, 1, 14);         // tag 0 ignored, slot 2 still pushed
    cycle(0, 0, 1, 0, 0, 0);          // tag 0 alone: count unchanged
    cycle(1, 1, 0, 0, 0, 0);

    // Random traffic long enough for head and tail to wrap several times.
    do_reset();
    for (int i = 0; i < 150; i++) begin
      bit a, b, fv1, fv2;
      int fr1, fr2, idx;
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      fv1 = 0; fv2 = 0; fr1 = 0; fr2 = 0;
      if (held.size() > 0 && $urandom_range(0, 99) < 60) begin
        idx = $urandom_range(0, held.size() - 1);
        fr1 = held[idx]; held.delete(idx); fv1 = 1;
      end else if ($urandom_range(0, 9) == 0) begin
        fv1 = 1; fr1 = 0;
      end
      if (held.size() > 0 && $urandom_range(0, 99) < 60) begin
        idx = $urandom_range(0, held.size() - 1);
        fr2 = held[idx]; held.delete(idx); fv2 = 1;
      end
      cycle(a, b, fv1, fr1, fv2, fr2);
    end

    // Fill to 63, overflow with a double free, confirm the flag is sticky.
    do_reset();
    for (int i = 0; i < 15; i++) cycle(0, 0, 1, 2 * i + 1, 1, 2 * i + 2);
    cycle(0, 0, 1, 31, 0, 0);
    cycle(0, 0, 1, 5, 1, 6);          // 65 would exceed the pool: dropped
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 9, 0, 0);          // exactly 64 is allowed
    cycle(1, 1, 1, 10, 1, 11);        // alloc and free balance at 64
    cycle(0, 0, 1, 3, 0, 0);          // overflow again
    cycle(1, 0, 0, 0, 0, 0);
    mid_op_reset();
    cycle(1, 1, 0, 0, 0, 0);          // first edge after reset is normal
    cycle(0, 0, 0, 0, 0, 0);

    @(posedge clk);
    #1;
    idle_inputs();
    repeat (4) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
